// File: rtl/cnna_pkg.sv
// Shared types and constants for the input-buffer read path.
package cnna_pkg;

  // Read controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  localparam int unsigned DEF_DSIZE = 32;
  localparam int unsigned DEF_ASIZE = 10;

  // Number of words addressed by an ASIZE-bit address.
  function automatic int unsigned depth_of(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

  localparam int unsigned DEF_DEPTH = depth_of(DEF_ASIZE);

endpackage

// File: rtl/ibuf_rd_ctrl_if.sv
// Valid/ready stream carrying one data word plus an end-of-transfer flag.
//
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high. While valid is high and ready is low, data and last hold
// their values, and valid stays high until the beat transfers. ready may
// change freely and carries no obligation when valid is low.
interface ibuf_stream_if
  import cnna_pkg::*;
#(
  parameter int DSIZE = 32
);
  logic             valid;
  logic             ready;
  logic             last;
  logic [DSIZE-1:0] data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/ibuf_skid_fifo.sv
// Two-entry FIFO of {last, data} that sits between the RAM read port and
// the output stream, absorbing the one-cycle RAM read latency.
module ibuf_skid_fifo
  import cnna_pkg::*;
#(
  parameter int DSIZE = 32
)
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic [DSIZE:0] wdata_i,
  output logic [1:0]     cnt_o,
  ibuf_stream_if.master  m
);

  logic [DSIZE:0] mem_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     cnt_q;
  logic [1:0]     cnt_d;
  logic           pop;
  logic           push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push when the head is leaving. The read controller's credit rule keeps
  // pushes from arriving when neither condition holds.
  assign pop     = (cnt_q != 2'd0) && m.ready;
  assign push_ok = push_i && ((cnt_q != 2'd2) || pop);

  // Occupancy update from the push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; storage is cleared so the outputs read zero
  // after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign m.valid           = (cnt_q != 2'd0);
  assign {m.last, m.data}  = mem_q[rd_ptr_q];
  assign cnt_o             = cnt_q;

endmodule

// File: rtl/ibuf_rd_ctrl.sv
// Read-side controller for the input-buffer RAM: sweeps a wrapping address
// range after a start command and streams the words out with a last flag.
module ibuf_rd_ctrl
  import cnna_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int ASIZE = 10
)
(
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic [ASIZE-1:0] I_base_addr,
  input  logic [ASIZE:0]   I_len,
  output logic             O_busy,
  output logic             O_done,
  output logic [ASIZE-1:0] O_ram_addr,
  output logic             O_ram_ce,
  output logic             O_ram_wr,
  output logic [DSIZE-1:0] O_ram_wdata,
  input  logic [DSIZE-1:0] I_ram_rdata,
  output logic             O_m_valid,
  output logic [DSIZE-1:0] O_m_data,
  output logic             O_m_last,
  input  logic             I_m_ready
);

  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(depth_of(ASIZE));

  rd_state_t        state_q, state_d;
  logic [ASIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ASIZE:0]   len_q, len_d;
  logic [ASIZE:0]   issue_cnt_q, issue_cnt_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;

  logic [ASIZE:0]   len_sat;
  logic [ASIZE:0]   issue_cnt_inc;
  logic [1:0]       fifo_cnt;
  logic [2:0]       credit_sum;
  logic             pop;
  logic             issue;
  logic             issue_last;
  logic             drain_empty;

  ibuf_stream_if #(.DSIZE(DSIZE)) m_if ();

  ibuf_skid_fifo #(.DSIZE(DSIZE)) u_fifo (
    .clk_i   (I_clk),
    .rst_i   (I_rst),
    .push_i  (inflight_q),
    .wdata_i ({inflight_last_q, I_ram_rdata}),
    .cnt_o   (fifo_cnt),
    .m       (m_if.master)
  );

  assign m_if.ready = I_m_ready;
  assign O_m_valid  = m_if.valid;
  assign O_m_data   = m_if.data;
  assign O_m_last   = m_if.last;

  // Lengths beyond the RAM size would re-read words; clamp to one full sweep.
  assign len_sat       = (I_len > DEPTH_C) ? DEPTH_C : I_len;
  assign issue_cnt_inc = issue_cnt_q + {{ASIZE{1'b0}}, 1'b1};

  // Credit: FIFO entries plus the word in flight may never exceed two,
  // unless a pop this cycle frees a slot for the word issued now.
  assign pop         = m_if.valid && I_m_ready;
  assign credit_sum  = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign issue       = (state_q == ST_RD) && (issue_cnt_q != len_q) &&
                       ((credit_sum < 3'd2) || pop);
  assign issue_last  = issue && (issue_cnt_inc == len_q);

  // The FIFO will be empty after this edge with nothing left to arrive, so
  // the final handshake is happening now or has already happened.
  assign drain_empty = !inflight_q &&
                       ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

  // Read-data arrival tracking: each ce produces a push one cycle later.
  assign inflight_d      = issue;
  assign inflight_last_d = issue_last;

  // Next-state, address and issue-counter logic.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          rd_addr_d   = I_base_addr;
          len_d       = len_sat;
          issue_cnt_d = '0;
          state_d     = (len_sat == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        if (issue) begin
          rd_addr_d   = rd_addr_q + {{(ASIZE-1){1'b0}}, 1'b1};
          issue_cnt_d = issue_cnt_inc;
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address, length and in-flight registers.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q         <= ST_IDLE;
      rd_addr_q       <= '0;
      len_q           <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_addr_q       <= rd_addr_d;
      len_q           <= len_d;
      issue_cnt_q     <= issue_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign O_busy      = (state_q != ST_IDLE);
  assign O_done      = (state_q == ST_DONE);
  assign O_ram_addr  = rd_addr_q;
  assign O_ram_ce    = issue;
  assign O_ram_wr    = 1'b0;
  assign O_ram_wdata = '0;

endmodule

// File: tb/tb_ibuf_rd_ctrl.sv
// Directed bench for ibuf_rd_ctrl with a behavioural 1-cycle RAM.
module tb_ibuf_rd_ctrl;
  import cnna_pkg::*;

  localparam int DSIZE = 32;
  localparam int ASIZE = 10;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ASIZE-1:0] base;
  logic [ASIZE:0]   len;
  logic             busy, done, ram_ce, ram_wr;
  logic [ASIZE-1:0] ram_addr;
  logic [DSIZE-1:0] ram_wdata;
  logic [DSIZE-1:0] ram_rdata = '0;
  logic [DSIZE-1:0] mem [1024];

  ibuf_stream_if #(.DSIZE(DSIZE)) s_if ();

  always #5 clk = ~clk;

  ibuf_rd_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .I_clk       (clk),
    .I_rst       (rst),
    .I_start     (start),
    .I_base_addr (base),
    .I_len       (len),
    .O_busy      (busy),
    .O_done      (done),
    .O_ram_addr  (ram_addr),
    .O_ram_ce    (ram_ce),
    .O_ram_wr    (ram_wr),
    .O_ram_wdata (ram_wdata),
    .I_ram_rdata (ram_rdata),
    .O_m_valid   (s_if.valid),
    .O_m_data    (s_if.data),
    .O_m_last    (s_if.last),
    .I_m_ready   (s_if.ready)
  );

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = a * 3;
  end

  always @(posedge clk) begin
    if (ram_ce) ram_rdata <= mem[ram_addr];
  end

  // ---------------- monitor (records only) ----------------
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  logic             mon_clr = 1'b0;
  logic [DSIZE-1:0] beat_q[$];
  logic             last_q[$];
  int               beat_cyc[$];
  logic [ASIZE-1:0] addr_q[$];
  int               ce_cnt, done_cnt, done_cyc, stall_err, credit_err, ovf_err;
  logic             prev_hold = 1'b0;
  logic [DSIZE-1:0] prev_data;
  logic             prev_last;
  logic [DSIZE-1:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_clr) begin
      beat_q.delete(); last_q.delete(); beat_cyc.delete(); addr_q.delete();
      ce_cnt = 0; done_cnt = 0; done_cyc = -1;
      stall_err = 0; credit_err = 0; ovf_err = 0;
    end
    if (!rst) begin
      if (prev_hold && (s_if.valid !== 1'b1 || s_if.data !== prev_data ||
                        s_if.last !== prev_last)) stall_err++;
      if (ram_ce === 1'b1) begin
        ce_cnt++;
        addr_q.push_back(ram_addr);
        if ((int'(dut.fifo_cnt) + int'(dut.inflight_q) >= 2) &&
            !(s_if.valid && s_if.ready)) credit_err++;
      end
      if (int'(dut.fifo_cnt) + int'(dut.inflight_q) > 2) credit_err++;
      if (dut.inflight_q && dut.fifo_cnt == 2'd2 && !(s_if.valid && s_if.ready)) ovf_err++;
      if (s_if.valid && s_if.ready) begin
        beat_q.push_back(s_if.data);
        last_q.push_back(s_if.last);
        beat_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_hold = s_if.valid && !s_if.ready;
      prev_data = s_if.data;
      prev_last = s_if.last;
    end else begin
      prev_hold = 1'b0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic do_start(input logic [ASIZE-1:0] b, input logic [ASIZE:0] l, output int c0);
    start = 1'b1; base = b; len = l;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  // mode 0: ready held high; mode 1: ready toggles every cycle.
  task automatic wait_done(input int budget, input int mode, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      if (mode == 1) s_if.ready = ~s_if.ready;
      tick();
      n++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic run_xfer(input logic [ASIZE-1:0] b, input logic [ASIZE:0] l,
                          input int mode, input int budget, output int c0, output bit ok);
    clear_mon();
    s_if.ready = 1'b1;
    do_start(b, l, c0);
    wait_done(budget, mode, ok);
    tick();
  endtask

  function automatic logic [DSIZE-1:0] beat_at(input int i);
    return (i >= 0 && i < beat_q.size()) ? beat_q[i] : 'x;
  endfunction

  function automatic int cyc_at(input int i);
    return (i >= 0 && i < beat_cyc.size()) ? beat_cyc[i] : -1;
  endfunction

  function automatic logic [15:0] last_mask();
    logic [15:0] m = '0;
    for (int i = 0; i < last_q.size() && i < 16; i++) if (last_q[i]) m[i] = 1'b1;
    return m;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base = '0; len = '0; s_if.ready = 1'b0;
    repeat (3) tick();
    total++;
    if ({busy, done, ram_ce, ram_wr, s_if.valid, s_if.last} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {busy, done, ram_ce, ram_wr, s_if.valid, s_if.last});
    end
    total++;
    if (ram_addr !== '0 || s_if.data !== '0 || ram_wdata !== '0) begin
      bad++; $display("FAIL reset_buses: addr=%h data=%h wdata=%h want 0", ram_addr, s_if.data, ram_wdata);
    end
    total++;
    if (dut.state_q !== ST_IDLE || dut.fifo_cnt !== 2'd0 || dut.inflight_q !== 1'b0) begin
      bad++; $display("FAIL reset_state: state=%0d cnt=%0d infl=%b want 0 0 0", dut.state_q, dut.fifo_cnt, dut.inflight_q);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int c0; bit ok;
    clear_mon();
    s_if.ready = 1'b1;
    do_start(10'h010, 11'd4, c0);
    total++;
    if (ram_ce !== 1'b1 || ram_addr !== 10'h010 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_first_issue: ce=%b addr=%h busy=%b want 1 010 1", ram_ce, ram_addr, busy);
    end
    wait_done(50, 0, ok);
    tick();
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: done not seen want done within 50 cycles"); end
    exp_q = '{32'h30, 32'h33, 32'h36, 32'h39};
    total++;
    if (beat_q.size() != 4) begin bad++; $display("FAIL basic_count: got %0d want 4", beat_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (beat_at(i) !== exp_q[i]) begin
        bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, beat_at(i), exp_q[i]);
      end
    end
    total++;
    if (last_mask() !== 16'h0008) begin bad++; $display("FAIL basic_last: got %h want 0008", last_mask()); end
    total++;
    if (cyc_at(0) != c0 + 2 || cyc_at(3) != c0 + 5) begin
      bad++; $display("FAIL basic_timing: first=%0d last=%0d want %0d %0d", cyc_at(0), cyc_at(3), c0 + 2, c0 + 5);
    end
    total++;
    if (done_cnt != 1 || done_cyc != c0 + 6) begin
      bad++; $display("FAIL basic_done: cnt=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, c0 + 6);
    end
    total++;
    if (ce_cnt != 4) begin bad++; $display("FAIL basic_ce_cycles: got %0d want 4", ce_cnt); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int c0; bit ok;
    run_xfer(10'h010, 11'd4, 1, 100, c0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_timeout: done not seen want done within 100 cycles"); end
    exp_q = '{32'h30, 32'h33, 32'h36, 32'h39};
    total++;
    if (beat_q.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", beat_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (beat_at(i) !== exp_q[i]) begin
        bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, beat_at(i), exp_q[i]);
      end
    end
    total++;
    if (last_mask() !== 16'h0008) begin bad++; $display("FAIL bp_last: got %h want 0008", last_mask()); end
    total++;
    if (stall_err != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
    total++;
    if (credit_err != 0 || ovf_err != 0) begin
      bad++; $display("FAIL bp_credit: credit=%0d ovf=%0d want 0 0", credit_err, ovf_err);
    end
    total++;
    if (ce_cnt != 4 || done_cnt != 1 || done_cyc != cyc_at(3) + 1) begin
      bad++; $display("FAIL bp_done: ce=%0d done=%0d cyc=%0d want 4 1 %0d", ce_cnt, done_cnt, done_cyc, cyc_at(3) + 1);
    end
  endtask

  task automatic test_wrap();
    int c0; bit ok;
    logic [ASIZE-1:0] exp_a [4];
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    run_xfer(10'h3FE, 11'd4, 0, 50, c0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_timeout: done not seen want done within 50 cycles"); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= addr_q.size() || addr_q[i] !== exp_a[i]) begin
        bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, (i < addr_q.size()) ? addr_q[i] : 10'h0, exp_a[i]);
      end
    end
    exp_q = '{32'hBFA, 32'hBFD, 32'h000, 32'h003};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (beat_at(i) !== exp_q[i]) begin
        bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, beat_at(i), exp_q[i]);
      end
    end
    total++;
    if (beat_q.size() != 4 || last_mask() !== 16'h0008) begin
      bad++; $display("FAIL wrap_last: count=%0d mask=%h want 4 0008", beat_q.size(), last_mask());
    end
  endtask

  task automatic test_len_zero();
    int c0;
    clear_mon();
    s_if.ready = 1'b1;
    do_start(10'h000, 11'd0, c0);
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL len0_pulse: done=%b busy=%b want 1 1", done, busy);
    end
    total++;
    if (ram_ce !== 1'b0 || s_if.valid !== 1'b0) begin
      bad++; $display("FAIL len0_quiet: ce=%b valid=%b want 0 0", ram_ce, s_if.valid);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL len0_end: done=%b busy=%b want 0 0", done, busy);
    end
    total++;
    if (ce_cnt != 0 || beat_q.size() != 0 || done_cnt != 1) begin
      bad++; $display("FAIL len0_counts: ce=%0d beats=%0d done=%0d want 0 0 1", ce_cnt, beat_q.size(), done_cnt);
    end
  endtask

  task automatic test_full_len();
    int c0; bit ok; int errs; int nlast;
    run_xfer(10'h000, 11'd1024, 0, 1200, c0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL full_timeout: done not seen want done within 1200 cycles"); end
    total++;
    if (beat_q.size() != 1024) begin bad++; $display("FAIL full_count: got %0d want 1024", beat_q.size()); end
    errs = 0; nlast = 0;
    for (int i = 0; i < beat_q.size(); i++) begin
      if (beat_q[i] !== DSIZE'(i * 3)) errs++;
      if (last_q[i]) nlast++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL full_data: got %0d wrong words want 0", errs); end
    total++;
    if (nlast != 1 || last_q.size() != 1024 || last_q[1023] !== 1'b1) begin
      bad++; $display("FAIL full_last: got %0d last flags want 1 on beat 1024", nlast);
    end
    total++;
    if (cyc_at(1023) - cyc_at(0) != 1023 || done_cyc != cyc_at(1023) + 1) begin
      bad++; $display("FAIL full_timing: span=%0d done=%0d want 1023 %0d", cyc_at(1023) - cyc_at(0), done_cyc, cyc_at(1023) + 1);
    end
    // Oversized length clamps to one full sweep starting at 0x100.
    run_xfer(10'h100, 11'h7FF, 0, 1200, c0, ok);
    total++;
    if (!ok || beat_q.size() != 1024 || ce_cnt != 1024) begin
      bad++; $display("FAIL sat_count: ok=%b beats=%0d ce=%0d want 1 1024 1024", ok, beat_q.size(), ce_cnt);
    end
    total++;
    if (beat_at(0) !== 32'h300 || beat_at(1023) !== 32'h2FD) begin
      bad++; $display("FAIL sat_data: first=%h last=%h want 300 2fd", beat_at(0), beat_at(1023));
    end
  endtask

  task automatic test_start_ignored();
    int c0; bit ok;
    clear_mon();
    s_if.ready = 1'b0;
    do_start(10'h020, 11'd6, c0);
    tick();
    start = 1'b1; base = 10'h100; len = 11'd2;
    tick();
    start = 1'b0;
    wait_done(100, 1, ok);
    tick();
    total++;
    if (!ok) begin bad++; $display("FAIL ign_timeout: done not seen want done within 100 cycles"); end
    exp_q = '{32'h60, 32'h63, 32'h66, 32'h69, 32'h6C, 32'h6F};
    total++;
    if (beat_q.size() != 6) begin bad++; $display("FAIL ign_count: got %0d want 6", beat_q.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (beat_at(i) !== exp_q[i]) begin
        bad++; $display("FAIL ign_data[%0d]: got %h want %h", i, beat_at(i), exp_q[i]);
      end
    end
    s_if.ready = 1'b1;
    repeat (5) tick();
    total++;
    if (busy !== 1'b0 || ce_cnt != 6 || done_cnt != 1 || last_mask() !== 16'h0020) begin
      bad++; $display("FAIL ign_after: busy=%b ce=%0d done=%0d mask=%h want 0 6 1 0020", busy, ce_cnt, done_cnt, last_mask());
    end
  endtask

  task automatic test_reset_abort();
    int c0; int n; int nb; int nce; bit ok;
    clear_mon();
    s_if.ready = 1'b1;
    do_start(10'h040, 11'd8, c0);
    n = 0;
    while (beat_q.size() < 2 && n < 20) begin tick(); n++; end
    total++;
    if (beat_q.size() < 2) begin bad++; $display("FAIL abort_timeout: got %0d beats want 2", beat_q.size()); end
    rst = 1'b1;
    tick();
    total++;
    if ({busy, done, ram_ce, s_if.valid, s_if.last} !== 5'b0 || ram_addr !== '0 || s_if.data !== '0) begin
      bad++; $display("FAIL abort_outputs: flags=%b addr=%h data=%h want 0 0 0",
                      {busy, done, ram_ce, s_if.valid, s_if.last}, ram_addr, s_if.data);
    end
    rst = 1'b0;
    nb = beat_q.size();
    nce = ce_cnt;
    repeat (10) tick();
    total++;
    if (beat_q.size() != nb || ce_cnt != nce || done_cnt != 0) begin
      bad++; $display("FAIL abort_quiet: beats=%0d ce=%0d done=%0d want %0d %0d 0", beat_q.size(), ce_cnt, done_cnt, nb, nce);
    end
    run_xfer(10'h050, 11'd2, 0, 50, c0, ok);
    total++;
    if (!ok || beat_at(0) !== 32'hF0 || beat_at(1) !== 32'hF3 || beat_q.size() != 2) begin
      bad++; $display("FAIL abort_restart: ok=%b beats=%0d d0=%h d1=%h want 1 2 f0 f3", ok, beat_q.size(), beat_at(0), beat_at(1));
    end
    total++;
    if (last_mask() !== 16'h0002 || done_cnt != 1) begin
      bad++; $display("FAIL abort_restart_last: mask=%h done=%0d want 0002 1", last_mask(), done_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_full_len();
    test_start_ignored();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ibuf_rd_ctrl.md
Name: ibuf_rd_ctrl

Overview:
- Read-side controller for the input-buffer dual-port RAM (block RAM, 1-cycle registered read).
- On a start command it sweeps a contiguous, wrapping address range on one RAM port with write tied off.
- It presents the words as a valid/ready stream with a last flag toward the compute pipeline.
- A 2-entry skid FIFO absorbs the RAM read latency, so throughput is 1 word/cycle under full backpressure correctness.

Parameters:
DSIZE, 32, RAM/stream data width
ASIZE, 10, RAM address width; DEPTH = 2^ASIZE words

Ports:
I_clk  in  1  single clock (also drives the connected RAM port)
I_rst  in  1  synchronous reset, active-high
I_start  in  1  start pulse; sampled only in IDLE
I_base_addr  in  ASIZE  first word address, captured on accepted start
I_len  in  ASIZE+1  word count 0..DEPTH, captured on accepted start
O_busy  out  1  high from accepted start until the O_done cycle, inclusive
O_done  out  1  1-cycle pulse after the final stream handshake
O_ram_addr  out  ASIZE  RAM read address
O_ram_ce  out  1  RAM read enable
O_ram_wr  out  1  constant 0
O_ram_wdata  out  DSIZE  constant 0
I_ram_rdata  in  DSIZE  RAM read data, valid the cycle after a ce cycle
O_m_valid  out  1  stream valid
O_m_data  out  DSIZE  stream data
O_m_last  out  1  high on the final beat only
I_m_ready  in  1  stream ready

Behaviour:
- Reset: every output is 0, FSM is IDLE, FIFO is empty, in-flight flag is cleared. Reset mid-transfer aborts it: no O_done and no further beats, and the next start behaves normally.
- Handshake: a beat transfers when O_m_valid and I_m_ready are both high. O_m_data and O_m_last stay stable while valid is high and ready is low. Valid never drops without a handshake.
- FSM states: IDLE, RD, DRAIN, DONE.
  - IDLE: I_start=1 captures base and len. len=0 goes to DONE; otherwise go to RD.
  - RD: issue reads (see next item). After the len-th issue, go to DRAIN.
  - DRAIN: when the FIFO is empty, nothing is in flight, and the last handshake is done, go to DONE.
  - DONE: O_done=1 for one cycle, O_busy=1 that cycle, then IDLE.
  - I_start outside IDLE is ignored.
- Read issue in RD: O_ram_ce=1 when (fifo_cnt + inflight) < 2, or when a pop happens this cycle. inflight is a register set on the cycle after ce.
  - Each issue advances the read address by 1, modulo DEPTH (wrap 2^ASIZE-1 -> 0).
  - The issue counter tracks issued words.
  - O_ram_addr is a register equal to the current read address.
- The FIFO pushes I_ram_rdata the cycle after each ce, together with a last flag for the word whose issue count equals len.
  - Push and pop may occur in the same cycle.
  - Overflow is impossible by the credit rule, and verification must check it never happens.
- Latency: I_start is sampled at clock edge E0. O_ram_ce is high in the cycle after E0. The first word is captured at E2, and O_m_valid rises after E2.
  - With I_m_ready held high, the N beats are consecutive, and O_done follows the cycle after the last beat.
- Widths: address arithmetic is ASIZE bits and wraps. The counters are ASIZE+1 bits. I_len > DEPTH saturates to DEPTH.

Decomposition:
- Shared package cnna_pkg holds the FSM state typedef (IDLE/RD/DRAIN/DONE) and a DEPTH localparam function of ASIZE.
- Sub-module ibuf_skid_fifo: 2-entry FIFO of {last, data}, width DSIZE+1, with push/pop/valid/count.
- The FSM, credit logic and address/issue counters live in ibuf_rd_ctrl.

Test Plan:
- Preload mem[a]=a*3; base=0x010, len=4, ready=1 -> beats 0x30,0x33,0x36,0x39 on consecutive cycles; last on beat 4; O_done one cycle later; ce high exactly 4 cycles.
- Same preload, ready pattern 1,0,1,0... -> same 4 words in order with no duplicates or drops; data stable while stalled; ce never high when fifo_cnt+inflight=2 without a pop.
- base=0x3FE, len=4 -> addresses 3FE, 3FF, 000, 001 and data 0xBFA, 0xBFD, 0x000, 0x003; last on the 0x003 beat.
- len=0 -> O_done pulse the cycle after start; O_busy high that one cycle; no ce and no valid. Then len=1024, base=0 with ready=1 -> 1024 consecutive beats, last on the 1024th.
- I_start pulsed mid-transfer -> ignored, base/len unchanged. I_rst asserted after beat 2 of len=8 -> next cycle all outputs 0 and no O_done; a fresh start with len=2 completes normally.
